fp_multiply_param: RTL and testbench

FP_MULTIPLY_PARAM -- requirements
Module: fp_multiply_param

---
 rtl/fp_multiply_param.sv | 217 +++++++++++++++++++++
 tb/tb_fp_multiply_param.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_multiply_param.sv
// Multi-cycle parameterised floating-point multiplier: shift-add significand product,
// normalise, round-to-nearest-even, constant latency of MAN_W+4 cycles for every operand class.
module fp_multiply_param #(
  parameter  int unsigned EXP_W      = 8,
  parameter  int unsigned MAN_W      = 23,
  localparam int unsigned DATA_WIDTH = 1 + EXP_W + MAN_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  busy_o,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  done_o,
  output logic [3:0]            flags_o
);

  localparam int unsigned LAT        = MAN_W + 4;
  localparam int unsigned MUL_CYCLES = LAT - 3;
  localparam int unsigned SIG_W      = MAN_W + 1;
  localparam int unsigned PROD_W     = 2 * SIG_W;
  localparam int unsigned XW         = EXP_W + 2;
  localparam int unsigned CNT_W      = $clog2(MUL_CYCLES + 1);
  localparam int unsigned BIAS       = (1 << (EXP_W - 1)) - 1;

  typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_t;

  state_t                  state, state_d;
  logic                    busy_d, done_d;
  logic [DATA_WIDTH-1:0]   result_d;
  logic [3:0]              flags_d;

  logic [PROD_W-1:0]       prod;
  logic [SIG_W-1:0]        mcand;
  logic [CNT_W-1:0]        cnt;
  logic [EXP_W-1:0]        ea_r, eb_r;
  logic                    sign_r;
  logic signed [XW-1:0]    exp_r;
  logic                    spec_r;
  logic [DATA_WIDTH-1:0]   spec_res_r, res_r;
  logic [3:0]              spec_flags_r, flags_r;

  // Operand classification (denormals treated as zero)
  logic [EXP_W-1:0]        ea, eb;
  logic [MAN_W-1:0]        ma, mb;
  logic                    a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, sgn;
  logic                    spec_hit;
  logic [DATA_WIDTH-1:0]   spec_res;
  logic [3:0]              spec_flags;

  assign ea     = A[MAN_W +: EXP_W];
  assign eb     = B[MAN_W +: EXP_W];
  assign ma     = A[MAN_W-1:0];
  assign mb     = B[MAN_W-1:0];
  assign sgn    = A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1];
  assign a_nan  = (&ea) & (|ma);
  assign b_nan  = (&eb) & (|mb);
  assign a_snan = a_nan & ~ma[MAN_W-1];
  assign b_snan = b_nan & ~mb[MAN_W-1];
  assign a_inf  = (&ea) & ~(|ma);
  assign b_inf  = (&eb) & ~(|mb);
  assign a_zero = ~(|ea);
  assign b_zero = ~(|eb);

  always_comb begin
    spec_hit   = 1'b0;
    spec_res   = '0;
    spec_flags = '0;
    if (a_nan || b_nan) begin
      spec_hit   = 1'b1;
      spec_res   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      spec_flags = {(a_snan | b_snan), 3'b000};
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      spec_hit   = 1'b1;
      spec_res   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      spec_flags = 4'b1000;
    end else if (a_inf || b_inf) begin
      spec_hit   = 1'b1;
      spec_res   = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      spec_hit   = 1'b1;
      spec_res   = {sgn, {(EXP_W+MAN_W){1'b0}}};
    end
  end

  // One shift-add step: conditionally add multiplicand to the upper half, then shift right
  logic [SIG_W:0] mul_sum;
  assign mul_sum = {1'b0, prod[PROD_W-1:SIG_W]} + (prod[0] ? {1'b0, mcand} : {(SIG_W+1){1'b0}});

  logic [XW-1:0] exp_base;
  assign exp_base = {2'b00, ea_r} + {2'b00, eb_r} - XW'(BIAS);

  // Rounding of the normalised product (leading one sits at PROD_W-1)
  logic [MAN_W-1:0]     man_keep;
  logic                 g_bit, r_bit, s_bit, rnd_up, carry;
  logic [MAN_W:0]       man_sum;
  logic signed [XW-1:0] exp_fin;
  logic [DATA_WIDTH-1:0] rnd_res;
  logic [3:0]           rnd_flags;

  assign man_keep = prod[PROD_W-2 -: MAN_W];
  assign g_bit    = prod[MAN_W];
  assign r_bit    = prod[MAN_W-1];
  assign s_bit    = |prod[MAN_W-2:0];
  assign rnd_up   = g_bit & (r_bit | s_bit | man_keep[0]);
  assign man_sum  = {1'b0, man_keep} + (MAN_W+1)'(rnd_up);
  assign carry    = man_sum[MAN_W];
  assign exp_fin  = exp_r + XW'(carry);

  always_comb begin
    rnd_res   = {sign_r, exp_fin[EXP_W-1:0], man_sum[MAN_W-1:0]};
    rnd_flags = {3'b000, (g_bit | r_bit | s_bit)};
    if (spec_r) begin
      rnd_res   = spec_res_r;
      rnd_flags = spec_flags_r;
    end else if (exp_fin >= $signed({2'b00, {EXP_W{1'b1}}})) begin
      rnd_res   = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_flags = 4'b0101;
    end else if (exp_fin[XW-1] || (exp_fin == '0)) begin
      rnd_res   = {sign_r, {(EXP_W+MAN_W){1'b0}}};
      rnd_flags = 4'b0011;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prod         <= '0;
      mcand        <= '0;
      cnt          <= '0;
      ea_r         <= '0;
      eb_r         <= '0;
      sign_r       <= 1'b0;
      exp_r        <= '0;
      spec_r       <= 1'b0;
      spec_res_r   <= '0;
      spec_flags_r <= '0;
      res_r        <= '0;
      flags_r      <= '0;
    end else begin
      case (state)
        IDLE: if (valid_i) begin
          prod         <= {{SIG_W{1'b0}}, 1'b1, ma};
          mcand        <= {1'b1, mb};
          cnt          <= '0;
          ea_r         <= ea;
          eb_r         <= eb;
          sign_r       <= sgn;
          spec_r       <= spec_hit;
          spec_res_r   <= spec_res;
          spec_flags_r <= spec_flags;
        end
        MUL: begin
          prod <= {mul_sum, prod[SIG_W-1:1]};
          cnt  <= cnt + CNT_W'(1);
        end
        NORM: begin
          if (prod[PROD_W-1]) begin
            exp_r <= exp_base + XW'(1);
          end else begin
            prod  <= prod << 1;
            exp_r <= exp_base;
          end
        end
        ROUND: begin
          res_r   <= rnd_res;
          flags_r <= rnd_flags;
        end
        default: ;
      endcase
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      Result  <= '0;
      flags_o <= '0;
    end else begin
      state   <= state_d;
      busy_o  <= busy_d;
      done_o  <= done_d;
      Result  <= result_d;
      flags_o <= flags_d;
    end
  end

  always_comb begin
    state_d  = state;
    busy_d   = busy_o;
    done_d   = 1'b0;
    result_d = Result;
    flags_d  = flags_o;
    case (state)
      IDLE: if (valid_i) begin
        state_d = MUL;
        busy_d  = 1'b1;
      end
      MUL:   if (cnt == CNT_W'(MUL_CYCLES - 1)) state_d = NORM;
      NORM:  state_d = ROUND;
      ROUND: state_d = DONE;
      DONE: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        result_d = res_r;
        flags_d  = flags_r;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp_multiply_param.sv
// Self-checking bench for fp_multiply_param: FP32 instance plus a half-precision instance,
// scoreboard queue of expected results, latency and control-protocol scenarios.
module tb_fp_multiply_param;

  localparam int LAT  = 27;
  localparam int HLAT = 14;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid, busy, done;
  logic [31:0] a, b, result;
  logic [3:0]  flags;

  logic        h_valid, h_busy, h_done;
  logic [15:0] h_a, h_b, h_res;
  logic [3:0]  h_flags;

  fp_multiply_param dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .A(a), .B(b),
    .busy_o(busy), .Result(result), .done_o(done), .flags_o(flags)
  );

  fp_multiply_param #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk_i(clk), .rst_i(rst), .valid_i(h_valid), .A(h_a), .B(h_b),
    .busy_o(h_busy), .Result(h_res), .done_o(h_done), .flags_o(h_flags)
  );

  typedef struct packed { logic [31:0] res; logic [3:0] flg; } exp_t;
  exp_t        sb_q[$];
  logic [19:0] h_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Drives one operation and waits (bounded) for done; lat=0 means no done seen
  task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                        output int lat, output logic [31:0] res, output logic [3:0] flg);
    @(negedge clk);
    a = op_a; b = op_b; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= LAT + 20; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    res = result; flg = flags;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (result !== 32'h0)  begin n_fail++; $display("FAIL reset_result got %h want 00000000", result); end
    n_checks++; if (flags !== 4'h0)    begin n_fail++; $display("FAIL reset_flags got %b want 0000", flags); end
    n_checks++; if (h_res !== 16'h0)   begin n_fail++; $display("FAIL reset_h_result got %h want 0000", h_res); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_arith();
    logic [31:0] tv_a[7] = '{32'h40000000, 32'hBF800000, 32'h3F800000, 32'h3FC00000,
                             32'h3F800001, 32'h3FFFFFFF, 32'h3F800003};
    logic [31:0] tv_b[7] = '{32'h40400000, 32'h40000000, 32'h3F800000, 32'h3FC00000,
                             32'h3FC00000, 32'h3FFFFFFF, 32'h3FC00000};
    exp_t        tv_e[7] = '{'{32'h40C00000, 4'h0}, '{32'hC0000000, 4'h0}, '{32'h3F800000, 4'h0},
                             '{32'h40100000, 4'h0}, '{32'h3FC00002, 4'h1}, '{32'h407FFFFE, 4'h1},
                             '{32'h3FC00004, 4'h1}};
    int lat; logic [31:0] res; logic [3:0] flg; exp_t e;
    for (int i = 0; i < 7; i++) begin
      sb_q.push_back(tv_e[i]);
      run_op(tv_a[i], tv_b[i], lat, res, flg);
      e = sb_q.pop_front();
      n_checks++; if (lat != LAT)    begin n_fail++; $display("FAIL arith%0d_latency got %0d want %0d", i, lat, LAT); end
      n_checks++; if (res !== e.res) begin n_fail++; $display("FAIL arith%0d_result got %h want %h", i, res, e.res); end
      n_checks++; if (flg !== e.flg) begin n_fail++; $display("FAIL arith%0d_flags got %b want %b", i, flg, e.flg); end
    end
    repeat (6) @(posedge clk);
    #1;
    n_checks++; if (result !== 32'h3FC00004) begin n_fail++; $display("FAIL hold_result got %h want 3FC00004", result); end
    n_checks++; if (done !== 1'b0)           begin n_fail++; $display("FAIL hold_done got %b want 0", done); end
  endtask

  task automatic test_special();
    logic [31:0] tv_a[9] = '{32'h7F800000, 32'h7F7FFFFF, 32'h00800000, 32'hFF800000, 32'h80000000,
                             32'h7F800001, 32'h7FC00001, 32'h00000001, 32'h80000001};
    logic [31:0] tv_b[9] = '{32'h00000000, 32'h40000000, 32'h3F000000, 32'h40000000, 32'h40400000,
                             32'h3F800000, 32'hC0000000, 32'h40000000, 32'h40000000};
    exp_t        tv_e[9] = '{'{32'h7FC00000, 4'b1000}, '{32'h7F800000, 4'b0101}, '{32'h00000000, 4'b0011},
                             '{32'hFF800000, 4'b0000}, '{32'h80000000, 4'b0000}, '{32'h7FC00000, 4'b1000},
                             '{32'h7FC00000, 4'b0000}, '{32'h00000000, 4'b0000}, '{32'h80000000, 4'b0000}};
    int lat; logic [31:0] res; logic [3:0] flg; exp_t e;
    for (int i = 0; i < 9; i++) begin
      sb_q.push_back(tv_e[i]);
      run_op(tv_a[i], tv_b[i], lat, res, flg);
      e = sb_q.pop_front();
      n_checks++; if (lat != LAT)    begin n_fail++; $display("FAIL special%0d_latency got %0d want %0d", i, lat, LAT); end
      n_checks++; if (res !== e.res) begin n_fail++; $display("FAIL special%0d_result got %h want %h", i, res, e.res); end
      n_checks++; if (flg !== e.flg) begin n_fail++; $display("FAIL special%0d_flags got %b want %b", i, flg, e.flg); end
    end
  endtask

  task automatic test_revalid();
    int lat = 0, extra = 0; exp_t e;
    sb_q.push_back('{32'h40C00000, 4'h0});
    @(negedge clk);
    a = 32'h40000000; b = 32'h40400000; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL revalid_busy got %b want 1", busy); end
    for (int k = 1; k <= LAT + 20; k++) begin
      if (k == 5) begin a = 32'h3F800000; b = 32'h3F800000; valid = 1'b1; end
      if (k == 6) valid = 1'b0;
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    e = sb_q.pop_front();
    n_checks++; if (lat != LAT)       begin n_fail++; $display("FAIL revalid_latency got %0d want %0d", lat, LAT); end
    n_checks++; if (result !== e.res) begin n_fail++; $display("FAIL revalid_result got %h want %h", result, e.res); end
    for (int k = 0; k < LAT + 10; k++) begin @(posedge clk); #1; if (done) extra++; end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL revalid_second_done got %0d want 0", extra); end
  endtask

  task automatic test_done_cycle_valid();
    int lat = 0, extra = 0;
    @(negedge clk);
    a = 32'h40000000; b = 32'h40000000; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    for (int k = 1; k <= LAT + 20; k++) begin
      @(posedge clk); #1;
      if (k == LAT - 1) begin a = 32'h3F800000; b = 32'h3F800000; valid = 1'b1; end
      if (done) begin lat = k; valid = 1'b0; break; end
    end
    valid = 1'b0;
    n_checks++; if (lat != LAT)            begin n_fail++; $display("FAIL donevalid_latency got %0d want %0d", lat, LAT); end
    n_checks++; if (result !== 32'h40800000) begin n_fail++; $display("FAIL donevalid_result got %h want 40800000", result); end
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL donevalid_busy got %b want 0", busy); end
    for (int k = 0; k < LAT + 10; k++) begin @(posedge clk); #1; if (done) extra++; end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL donevalid_extra_done got %0d want 0", extra); end
  endtask

  task automatic test_reset_abort();
    int extra = 0;
    @(negedge clk);
    a = 32'h40000000; b = 32'h40400000; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (5) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL abort_result got %h want 00000000", result); end
    n_checks++; if (flags !== 4'h0)   begin n_fail++; $display("FAIL abort_flags got %b want 0000", flags); end
    for (int k = 0; k < LAT + 10; k++) begin @(posedge clk); #1; if (done) extra++; end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL abort_done got %0d want 0", extra); end
  endtask

  task automatic test_reset_priority();
    int extra = 0;
    @(negedge clk);
    rst = 1'b1; valid = 1'b1; a = 32'h40000000; b = 32'h40400000;
    @(posedge clk); #1;
    rst = 1'b0; valid = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstprio_busy got %b want 0", busy); end
    for (int k = 0; k < LAT + 10; k++) begin @(posedge clk); #1; if (done || busy) extra++; end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL rstprio_activity got %0d want 0", extra); end
  endtask

  task automatic test_half();
    logic [15:0] tv_a[2] = '{16'h4000, 16'h3C00};
    logic [15:0] tv_b[2] = '{16'h4200, 16'hBC00};
    logic [19:0] tv_e[2] = '{{16'h4600, 4'h0}, {16'hBC00, 4'h0}};
    logic [19:0] e;
    int lat;
    for (int i = 0; i < 2; i++) begin
      h_q.push_back(tv_e[i]);
      @(negedge clk);
      h_a = tv_a[i]; h_b = tv_b[i]; h_valid = 1'b1;
      @(posedge clk); #1;
      h_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= HLAT + 20; k++) begin
        @(posedge clk); #1;
        if (h_done) begin lat = k; break; end
      end
      e = h_q.pop_front();
      n_checks++; if (lat != HLAT)           begin n_fail++; $display("FAIL half%0d_latency got %0d want %0d", i, lat, HLAT); end
      n_checks++; if (h_res !== e[19:4])     begin n_fail++; $display("FAIL half%0d_result got %h want %h", i, h_res, e[19:4]); end
      n_checks++; if (h_flags !== e[3:0])    begin n_fail++; $display("FAIL half%0d_flags got %b want %b", i, h_flags, e[3:0]); end
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; a = '0; b = '0;
    h_valid = 1'b0; h_a = '0; h_b = '0;
    test_reset();
    test_arith();
    test_special();
    test_revalid();
    test_done_cycle_valid();
    test_reset_abort();
    test_reset_priority();
    test_half();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
